// File: rtl/truth_table_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// tt_seq_pkg
//   Shared types and constants for the truth-table sequencer.
//   - tt_state_e   : sequencer FSM states
//   - N_IN_DEF     : default number of function-unit inputs
//   - N_VEC_DEF    : number of input vectors swept (2**N_IN_DEF)
//   - HOLD_W       : width of the per-vector hold counter
//   - hold_last()  : terminal hold count for a given hold length
// ---------------------------------------------------------------------------
package tt_seq_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int N_VEC_DEF = 1 << N_IN_DEF;
  localparam int HOLD_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  // Hold counter value on which the current vector is sampled.
  function automatic logic [HOLD_W-1:0] hold_last(input int hold_cycles);
    return HOLD_W'(hold_cycles - 1);
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer_if
//   Host-side control/status bundle of the truth-table sequencer.
//   master : host (drives start, abort, exp_mask; reads results)
//   slave  : sequencer (reads controls; drives status and results)
//   Signals:
//     start, abort      sweep control
//     exp_mask          expected minterm mask, bit k = expected f for vector k
//     busy, done        sweep in progress / one-cycle completion pulse
//     pass              last completed sweep had zero mismatches
//     table_out         captured truth table
//     mismatch_cnt      number of mismatching vectors
//     first_fail_idx    lowest mismatching vector, valid when fail_valid
//     aborted           last sweep was terminated by abort
// ---------------------------------------------------------------------------
interface truth_table_sequencer_if #(
  parameter int N_IN = 4
);
  localparam int N_VEC = 1 << N_IN;

  logic             start;
  logic             abort;
  logic [N_VEC-1:0] exp_mask;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_VEC-1:0] table_out;
  logic [N_IN:0]    mismatch_cnt;
  logic [N_IN-1:0]  first_fail_idx;
  logic             fail_valid;
  logic             aborted;

  modport master (
    output start, abort, exp_mask,
    input  busy, done, pass, table_out, mismatch_cnt,
           first_fail_idx, fail_valid, aborted
  );

  modport slave (
    input  start, abort, exp_mask,
    output busy, done, pass, table_out, mismatch_cnt,
           first_fail_idx, fail_valid, aborted
  );

endinterface

// File: rtl/truth_table_sequencer_vec_stepper.sv
// ---------------------------------------------------------------------------
// vec_stepper
//   Hold counter plus vector index counter for the truth-table sweep.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     clear          return both counters to zero (new sweep or abort)
//     enable         advance the hold counter this cycle
//     idx            current vector index (registered)
//     sample_strobe  this edge samples vector idx
//     last_vec       idx is the final vector
// ---------------------------------------------------------------------------
module vec_stepper
  import tt_seq_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  output logic [N_IN-1:0] idx,
  output logic            sample_strobe,
  output logic            last_vec
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = hold_last(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold;

  assign sample_strobe = enable && (hold == HOLD_LAST);
  assign last_vec      = (idx == {N_IN{1'b1}});

  // After the final sample the index returns to zero instead of wrapping
  // through the increment, so the unit is left driven with vector 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold <= '0;
      idx  <= '0;
    end else if (sample_strobe) begin
      hold <= '0;
      idx  <= last_vec ? '0 : idx + N_IN'(1);
    end else if (enable) begin
      hold <= hold + HOLD_W'(1);
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer
//   Sweeps a combinational function unit through all 2**N_IN input vectors
//   in ascending order, captures its output into a truth table and checks
//   it against an expected minterm mask latched when the sweep starts.
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     bus       host control/status (slave side)
//     vec_out   vector driven into the unit; [3]=A .. [0]=D for N_IN=4
//     f_in      unit output f
//   Parameters:
//     N_IN         number of function inputs
//     HOLD_CYCLES  cycles each vector is held before sampling (1..15)
// ---------------------------------------------------------------------------
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  truth_table_sequencer_if.slave   bus,
  output logic [N_IN-1:0]          vec_out,
  input  logic                     f_in
);

  localparam int N_VEC = 1 << N_IN;

  tt_state_e        state;
  logic [N_VEC-1:0] mask_q;
  logic [N_VEC-1:0] table_q;
  logic [N_IN:0]    cnt_q;
  logic [N_IN:0]    cnt_next;
  logic [N_IN-1:0]  ffi_q;
  logic             fv_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             aborted_q;

  logic [N_IN-1:0]  idx;
  logic             sample_strobe;
  logic             last_vec;
  logic             accept_start;
  logic             take_abort;
  logic             step_en;
  logic             miss;

  assign accept_start = (state == IDLE)  && bus.start;
  assign take_abort   = (state == SWEEP) && bus.abort;
  // An abort on a sampling edge suppresses the strobe, discarding that sample.
  assign step_en      = (state == SWEEP) && !bus.abort;

  vec_stepper #(
    .N_IN        (N_IN),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_stepper (
    .clk           (clk),
    .rst           (rst),
    .clear         (accept_start || take_abort),
    .enable        (step_en),
    .idx           (idx),
    .sample_strobe (sample_strobe),
    .last_vec      (last_vec)
  );

  assign miss     = f_in ^ mask_q[idx];
  assign cnt_next = cnt_q + {{N_IN{1'b0}}, miss};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask_q    <= '0;
      table_q   <= '0;
      cnt_q     <= '0;
      ffi_q     <= '0;
      fv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mask_q    <= bus.exp_mask;
            table_q   <= '0;
            cnt_q     <= '0;
            ffi_q     <= '0;
            fv_q      <= 1'b0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= SWEEP;
          end
        end

        SWEEP: begin
          if (bus.abort) begin
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            pass_q    <= 1'b0;
            state     <= IDLE;
          end else if (sample_strobe) begin
            table_q[idx] <= f_in;
            cnt_q        <= cnt_next;
            if (miss && !fv_q) begin
              ffi_q <= idx;
              fv_q  <= 1'b1;
            end
            // The verdict uses cnt_next so the final vector's result counts.
            if (last_vec) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (cnt_next == '0);
              state  <= DONE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign vec_out            = idx;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.table_out      = table_q;
  assign bus.mismatch_cnt   = cnt_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.fail_valid     = fv_q;
  assign bus.aborted        = aborted_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Testbench for truth_table_sequencer: two instances (hold 2 and hold 1)
// share clock and reset; sel chooses which one receives start/abort and
// which one is observed. The function unit is a lookup into unit_tt.
module tb_truth_table_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        start_drv;
  logic        abort_drv;
  logic [15:0] mask_drv;
  logic [15:0] unit_tt;

  logic [3:0]  vec0, vec1;
  logic        f0, f1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  truth_table_sequencer_if #(.N_IN(4)) bus0 ();
  truth_table_sequencer_if #(.N_IN(4)) bus1 ();

  assign bus0.start    = start_drv && (sel == 0);
  assign bus0.abort    = abort_drv && (sel == 0);
  assign bus0.exp_mask = mask_drv;
  assign bus1.start    = start_drv && (sel == 1);
  assign bus1.abort    = abort_drv && (sel == 1);
  assign bus1.exp_mask = mask_drv;

  assign f0 = unit_tt[vec0];
  assign f1 = unit_tt[vec1];

  truth_table_sequencer #(.N_IN(4), .HOLD_CYCLES(2)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus0),
    .vec_out (vec0),
    .f_in    (f0)
  );

  truth_table_sequencer #(.N_IN(4), .HOLD_CYCLES(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1),
    .vec_out (vec1),
    .f_in    (f1)
  );

  // Observed outputs of the selected instance.
  logic        o_busy, o_done, o_pass, o_fv, o_aborted;
  logic [15:0] o_table;
  logic [4:0]  o_cnt;
  logic [3:0]  o_ffi, o_vec;

  always_comb begin
    o_busy    = (sel == 1) ? bus1.busy           : bus0.busy;
    o_done    = (sel == 1) ? bus1.done           : bus0.done;
    o_pass    = (sel == 1) ? bus1.pass           : bus0.pass;
    o_fv      = (sel == 1) ? bus1.fail_valid     : bus0.fail_valid;
    o_aborted = (sel == 1) ? bus1.aborted        : bus0.aborted;
    o_table   = (sel == 1) ? bus1.table_out      : bus0.table_out;
    o_cnt     = (sel == 1) ? bus1.mismatch_cnt   : bus0.mismatch_cnt;
    o_ffi     = (sel == 1) ? bus1.first_fail_idx : bus0.first_fail_idx;
    o_vec     = (sel == 1) ? vec1                : vec0;
  end

  typedef struct {
    logic [15:0] unit;
    logic [15:0] mask;
    logic [15:0] exp_table;
    int          exp_cnt;
    int          exp_ffi;
    logic        exp_fv;
    logic        exp_pass;
  } vec_rec_t;

  vec_rec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (sel=%0d, t=%0t)",
               name, actual, expected, sel, $time);
    end
  endtask

  task automatic checkResults(input logic [15:0] exp_table, input int exp_cnt,
                              input int exp_ffi, input logic exp_fv,
                              input logic exp_pass);
    checkOutput("table_out",      32'(o_table), 32'(exp_table));
    checkOutput("mismatch_cnt",   32'(o_cnt),   32'(exp_cnt));
    checkOutput("first_fail_idx", 32'(o_ffi),   32'(exp_ffi));
    checkOutput("fail_valid",     32'(o_fv),    32'(exp_fv));
    checkOutput("pass",           32'(o_pass),  32'(exp_pass));
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"},    32'(o_busy),    32'd0);
    checkOutput({tag, "_done"},    32'(o_done),    32'd0);
    checkOutput({tag, "_aborted"}, 32'(o_aborted), 32'd0);
    checkOutput({tag, "_vec_out"}, 32'(o_vec),     32'd0);
    checkResults(16'h0000, 0, 0, 1'b0, 1'b0);
  endtask

  // Launches one sweep on the selected instance and waits for done.
  // With poke set, a second start with an inverted mask is pulsed
  // mid-sweep; it must have no effect. Returns with done visible.
  task automatic applyStimulus(input logic [15:0] mask, input bit poke,
                               output int lat);
    int hold = (sel == 1) ? 1 : 2;
    lat = -1;
    mask_drv = mask;
    @(negedge clk);
    start_drv = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_drv = 1'b0;
        checkOutput("busy_after_start", 32'(o_busy), 32'd1);
      end
      if (poke && c == 6) begin
        start_drv = 1'b1;
        mask_drv  = ~mask;
      end
      if (poke && c == 7) begin
        start_drv = 1'b0;
        mask_drv  = mask;
      end
      if (o_done) begin
        lat = c;
        break;
      end
      if (c <= 16 * hold)
        checkOutput("vec_out_step", 32'(o_vec), 32'((c - 1) / hold));
    end
    checkOutput("done_latency", 32'(lat), 32'(16 * hold + 1));
    checkOutput("busy_at_done", 32'(o_busy), 32'd0);
    checkOutput("vec_out_at_done", 32'(o_vec), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] diff;
    int          e_ffi;
    bit          seen_done;

    vecs[0] = '{16'hF000, 16'hF000, 16'hF000,  0,  0, 1'b0, 1'b1};
    vecs[1] = '{16'hF000, 16'hF001, 16'hF000,  1,  0, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16,  0, 1'b1, 1'b0};
    vecs[3] = '{16'hAAAA, 16'h5555, 16'hAAAA, 16,  0, 1'b1, 1'b0};
    vecs[4] = '{16'hF000, 16'h7000, 16'hF000,  1, 15, 1'b1, 1'b0};
    vecs[5] = '{16'h0130, 16'h0110, 16'h0130,  1,  5, 1'b1, 1'b0};

    sel = 0; start_drv = 0; abort_drv = 0; mask_drv = 16'h0; unit_tt = 16'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkIdleZero("reset0");
    sel = 1;
    checkIdleZero("reset1");
    rst = 1'b0;

    // Directed table on both hold settings.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 6; i++) begin
        unit_tt = vecs[i].unit;
        applyStimulus(vecs[i].mask, 1'b0, lat);
        checkResults(vecs[i].exp_table, vecs[i].exp_cnt, vecs[i].exp_ffi,
                     vecs[i].exp_fv, vecs[i].exp_pass);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(o_done), 32'd0);
        checkResults(vecs[i].exp_table, vecs[i].exp_cnt, vecs[i].exp_ffi,
                     vecs[i].exp_fv, vecs[i].exp_pass);
      end
    end

    // abort while idle is ignored; results hold.
    sel = 0;
    abort_drv = 1'b1;
    @(negedge clk);
    abort_drv = 1'b0;
    @(negedge clk);
    checkOutput("idle_abort_aborted", 32'(o_aborted), 32'd0);
    checkResults(vecs[5].exp_table, 1, 5, 1'b1, 1'b0);

    // start held high; mask changed after acceptance has no effect.
    sel = 0; unit_tt = 16'hF000; mask_drv = 16'hF000; lat = -1;
    @(negedge clk);
    start_drv = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 5) mask_drv = 16'h0000;
      if (o_done) begin
        lat = c;
        break;
      end
    end
    checkOutput("held_start_latency", 32'(lat), 32'd33);
    checkResults(16'hF000, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("held_start_idle_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    checkOutput("held_start_relaunch", 32'(o_busy), 32'd1);
    start_drv = 1'b0; abort_drv = 1'b1;
    @(negedge clk);
    abort_drv = 1'b0;
    checkOutput("relaunch_abort", 32'(o_aborted), 32'd1);

    // abort at edge 10: samples of vectors 0..3 are kept.
    unit_tt = 16'hFFFF; mask_drv = 16'h0000;
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (9) @(negedge clk);
    abort_drv = 1'b1;
    @(negedge clk);
    abort_drv = 1'b0;
    checkOutput("abort_busy",    32'(o_busy),    32'd0);
    checkOutput("abort_aborted", 32'(o_aborted), 32'd1);
    checkOutput("abort_vec_out", 32'(o_vec),     32'd0);
    checkResults(16'h000F, 4, 0, 1'b1, 1'b0);
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_done) seen_done = 1;
    end
    checkOutput("abort_no_done", 32'(seen_done), 32'd0);

    // reset at edge 20 mid-sweep, then a fresh full sweep.
    unit_tt = 16'hF000; mask_drv = 16'hF000;
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdleZero("midreset");
    applyStimulus(16'hF000, 1'b0, lat);
    checkResults(16'hF000, 0, 0, 1'b0, 1'b1);

    // Random functions and masks against the counting model.
    for (int r = 0; r < 20; r++) begin
      sel     = int'($urandom_range(0, 1));
      unit_tt = 16'($urandom);
      mask_drv = ($urandom_range(0, 3) == 0) ? unit_tt : 16'($urandom);
      diff  = unit_tt ^ mask_drv;
      e_ffi = 0;
      for (int k = 15; k >= 0; k--)
        if (diff[k]) e_ffi = k;
      applyStimulus(mask_drv, 1'b1, lat);
      checkResults(unit_tt, $countones(diff), e_ffi, diff != 16'h0,
                   diff == 16'h0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Sequencer that sweeps a 4-input combinational function unit (inputs A,B,C,D, output f) through all 16 input vectors in ascending order.
- Captures the unit's output into a 16-bit truth table and compares it against an expected minterm mask latched at start.
- Reports pass/fail, mismatch count and first failing index.
- Sits between a control/host register block and the function unit; replaces hand-written vector sweeps with an on-chip self-check.

Parameters:
N_IN, 4, number of function inputs; N_VEC = 2**N_IN vectors.
HOLD_CYCLES, 2, cycles each vector is held before f_in is sampled; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  begin a sweep; accepted only in IDLE
abort  input  1  terminate a sweep in progress; no done pulse
exp_mask  input  N_VEC  expected output; bit k = expected f for vector k; latched on accepted start
f_in  input  1  function unit output f
vec_out  output  N_IN  drives the unit; vec_out[3]=A, [2]=B, [1]=C, [0]=D
busy  output  1  high while sweeping
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  1 when the last completed sweep had zero mismatches
table_out  output  N_VEC  captured truth table; bit k = sampled f for vector k
mismatch_cnt  output  N_IN+1  number of mismatching vectors, 0..16
first_fail_idx  output  N_IN  index of the lowest mismatching vector
fail_valid  output  1  first_fail_idx is meaningful
aborted  output  1  the last sweep was terminated by abort

Behaviour:
- Reset (rst=1 at any edge, including mid-sweep): state=IDLE; all outputs 0; latched mask 0; rst has priority over start and abort.
- States: IDLE, SWEEP, DONE.
- IDLE: on start=1 at edge E0:
  - latch exp_mask; clear table_out, mismatch_cnt, fail_valid, first_fail_idx, pass and aborted;
  - set idx=0, hold=0, busy=1; go to SWEEP.
- SWEEP:
  - vec_out = idx (registered).
  - Each edge with hold<HOLD_CYCLES-1 increments hold.
  - At the edge with hold==HOLD_CYCLES-1:
    - table_out[idx] <= f_in;
    - if f_in != mask[idx]: mismatch_cnt += 1; if fail_valid==0, set first_fail_idx=idx and fail_valid=1;
    - hold <= 0; idx <= idx+1.
  - Vector k is driven for exactly HOLD_CYCLES cycles and sampled at edge E0+(k+1)*HOLD_CYCLES.
  - The sample of idx=15 goes to DONE; idx does not wrap and vec_out returns to 0.
- DONE: lasts one cycle.
  - done=1, busy=0, pass=(mismatch_cnt==0).
  - Next edge returns to IDLE and done=0.
  - done rises after edge E0+16*HOLD_CYCLES; for HOLD_CYCLES=2 that is edge 32.
- abort:
  - Honoured only in SWEEP, at any edge.
  - Next state IDLE; busy=0, aborted=1, vec_out=0, pass=0, no done.
  - A sample scheduled on the same edge is discarded; table_out and counters keep their partial values.
  - Ignored in IDLE and DONE.
- start while busy or in DONE is ignored; no queueing. start held high continuously launches a new sweep on the first edge back in IDLE.
- exp_mask changes after acceptance have no effect on the sweep in progress.
- Results (table_out, mismatch_cnt, first_fail_idx, fail_valid, pass) hold until the next accepted start or rst.
- mismatch_cnt saturation is impossible by width; no wrap logic required.

Decomposition:
- Package tt_seq_pkg:
  - state enum {IDLE, SWEEP, DONE};
  - N_IN default and derived N_VEC;
  - HOLD counter width constant (4 bits).
- Sub-module vec_stepper: the hold counter and idx counter with clear/enable, producing a sample_strobe output and a last_vec flag.
- Top level holds the FSM, mask latch, capture and compare logic.

Test Plan:
- Unit model f=A&B, exp_mask=16'hF000, HOLD_CYCLES=2, start at edge 0 -> vec_out steps 0..15 every 2 cycles, done at edge 32, table_out=16'hF000, mismatch_cnt=0, pass=1, fail_valid=0.
- Same model, exp_mask=16'hF001 -> mismatch_cnt=1, first_fail_idx=0, fail_valid=1, pass=0; f_in tied 0 with exp_mask=16'hFFFF -> mismatch_cnt=16, table_out=0.
- start held high and exp_mask switched to 16'h0000 at edge 5 -> single sweep judged against the original 16'hF000 mask (pass=1); a second sweep starts on the edge after done.
- abort at edge 10 -> busy=0, aborted=1, vec_out=0 next cycle, no done pulse, table_out keeps bits 0..3 only.
- rst at edge 20 mid-sweep -> all outputs 0 next cycle; a fresh start then completes normally with done at +32.
- HOLD_CYCLES=1 -> each vector held 1 cycle, done at edge 16, table_out identical to the HOLD_CYCLES=2 result.
